// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single synchronous single-port RAM.
// Port 0 is the CPU data port, port 1 the loader/DMA port. Every access runs
// through a three-state FSM (IDLE -> ACCESS -> RESP), so one transaction takes
// three cycles from the arbitration edge to its completion pulse.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  defined   -> fixed priority, port 0 wins every tie,
//                                       no last-grant register.
//                          undefined -> round-robin on ties, port 0 takes the
//                                       first tie after reset.
//
// Parameters:
//   RAM_AW     RAM word-address width
//   RAM_BYTES  RAM size in bytes; byte addresses >= RAM_BYTES are out of range
//
// Ports:
//   clk, reset_n              clock (rising edge), asynchronous active-low reset
//   req0/req1                 access request, held until the matching gnt
//   addr0/addr1               byte address (bits [1:0] ignored)
//   wdata0/wdata1, we0/we1    write data, 1 = write / 0 = read
//   gnt0/gnt1                 one-cycle grant pulse (ACCESS state)
//   rvalid0/rvalid1           one-cycle completion pulse (RESP state)
//   err0/err1                 out-of-range flag, valid with rvalid
//   rdata0/rdata1             read data, valid with rvalid, 0 otherwise
//   mem_en, mem_we            RAM strobe and write enable
//   mem_addr, mem_wdata       RAM word address and write data
//   mem_rdata                 RAM read data, valid one cycle after mem_en
//   busy                      high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned RAM_AW    = 15,
    parameter logic [31:0] RAM_BYTES = 32'h00020000
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req0,
    input  logic              req1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    input  logic              we0,
    input  logic              we1,

    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              err0,
    output logic              err1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,

    output logic              mem_en,
    output logic              mem_we,
    output logic [RAM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                port_q, port_d;         // winning port id
    logic [RAM_AW-1:0]   word_q, word_d;         // latched word address
    logic [31:0]         wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                in_range_q, in_range_d; // latched range check

    // -------------------------------------------------------------------------
    // Per-port request views so the arbitration and output logic can index by
    // port number instead of duplicating code.
    // -------------------------------------------------------------------------
    logic [1:0]  req_v;
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [1:0]  we_v;

    assign req_v      = {req1, req0};
    assign addr_v[0]  = addr0;
    assign addr_v[1]  = addr1;
    assign wdata_v[0] = wdata0;
    assign wdata_v[1] = wdata1;
    assign we_v       = {we1, we0};

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic any_req;
    logic win_port;

    assign any_req = |req_v;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Port 1 only wins when port 0 is not asking.
    assign win_port = ~req_v[0] & req_v[1];
`else
    // last_q remembers the port granted most recently; a tie goes to the
    // other one. Resetting it to port 1 hands the first tie to port 0.
    logic last_q, last_d;

    assign win_port = (req_v[0] & req_v[1]) ? ~last_q : req_v[1];

    always_comb begin
        last_d = last_q;
        if ((state_q == ST_IDLE) && any_req) begin
            last_d = win_port;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    logic [31:0] win_addr;
    logic        win_in_range;

    assign win_addr = addr_v[win_port];
    // RAM_BYTES is word aligned, so comparing the raw byte address is the
    // same as comparing with bits [1:0] cleared.
    assign win_in_range = (win_addr < RAM_BYTES);

    // -------------------------------------------------------------------------
    // FSM next state and request capture
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        in_range_d = in_range_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    port_d     = win_port;
                    word_d     = win_addr[RAM_AW+1:2];
                    wdata_d    = wdata_v[win_port];
                    we_d       = we_v[win_port];
                    in_range_d = win_in_range;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            port_q     <= 1'b0;
            word_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            in_range_q <= in_range_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Everything is decoded from the registered state, so the
    // asynchronous reset clears the strobes and pulses immediately (a write
    // in flight loses mem_we without waiting for a clock edge).
    // -------------------------------------------------------------------------
    logic st_access;
    logic st_resp;
    logic rd_ok;

    assign st_access = (state_q == ST_ACCESS);
    assign st_resp   = (state_q == ST_RESP);
    // RAM data returns in RESP, one cycle after the ACCESS strobe.
    assign rd_ok     = st_resp & ~we_q & in_range_q;

    assign busy      = (state_q != ST_IDLE);
    assign mem_en    = st_access & in_range_q;
    assign mem_we    = st_access & in_range_q & we_q;
    assign mem_addr  = word_q;
    assign mem_wdata = wdata_q;

    logic [1:0]  gnt_v;
    logic [1:0]  rvalid_v;
    logic [1:0]  err_v;
    logic [31:0] rdata_v [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic sel;
            assign sel          = (port_q == 1'(gi));
            assign gnt_v[gi]    = st_access & sel;
            assign rvalid_v[gi] = st_resp & sel;
            assign err_v[gi]    = st_resp & sel & ~in_range_q;
            assign rdata_v[gi]  = (rd_ok & sel) ? mem_rdata : 32'h0;
        end
    endgenerate

    assign gnt0    = gnt_v[0];
    assign gnt1    = gnt_v[1];
    assign rvalid0 = rvalid_v[0];
    assign rvalid1 = rvalid_v[1];
    assign err0    = err_v[0];
    assign err1    = err_v[1];
    assign rdata0  = rdata_v[0];
    assign rdata1  = rdata_v[1];

endmodule
